// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants, pad drive types and helpers for the GPIO bank
package gpio_pkg;

    localparam int GPIO_MAX_CH       = 32;
    localparam int GPIO_DEF_FILT_CNT = 4;

    typedef enum logic {
        PAD_PUSH_PULL  = 1'b0,
        PAD_OPEN_DRAIN = 1'b1
    } pad_mode_e;

    typedef struct packed {
        logic en;
        logic val;
    } pad_drv_t;

    // ceil(log2(filt_cnt + 1)); filt_cnt is limited to 1..255 so 8 bits always suffice
    function automatic int gpio_cnt_width(input int filt_cnt);
        int w;
        w = 1;
        for (int i = 1; i < 9; i++) begin
            if ((1 << i) < (filt_cnt + 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Open-drain only ever pulls low; a high level comes from the external pull-up.
    function automatic pad_drv_t gpio_pad_drive(input pad_mode_e mode, input logic oe, input logic dout);
        pad_drv_t drv;
        drv.en  = 1'b0;
        drv.val = 1'b0;
        if (oe) begin
            if (mode == PAD_PUSH_PULL) begin
                drv.en  = 1'b1;
                drv.val = dout;
            end else if (!dout) begin
                drv.en  = 1'b1;
                drv.val = 1'b0;
            end
        end
        return drv;
    endfunction

endpackage

// File: rtl/gpio_filter.sv
// rtl/gpio_filter.sv - per-channel synchroniser, optional glitch filter (GPIO_BANK_FILTER_EN) and edge detect
module gpio_filter
    import gpio_pkg::*;
#(
    parameter int   FILT_CNT = GPIO_DEF_FILT_CNT,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic din_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;

    // two-flop synchroniser; resets to the pull level so nothing toggles at release
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_BANK_FILTER_EN
    localparam int            CW       = gpio_cnt_width(FILT_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          din_q;
    logic          din_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;

    // count consecutive disagreeing cycles; the FILT_CNT-th one accepts the new level
    always_comb begin
        cnt_d  = '0;
        din_d  = din_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q != din_q) begin
            if (cnt_q == CNT_LAST) begin
                din_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // filter state; a reset mid-count throws the partial count away
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            din_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            din_q  <= din_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign din_o  = din_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    // the filter depth has no meaning without the filter
    localparam int unused_filt_cnt = FILT_CNT;

    logic prev_q;

    // previous synchroniser level, for edge detection against the live one
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= sync2_q;
        end
    end

    assign din_o  = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;
`endif

endmodule

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO pad bank with registered drive and filtered inputs; GPIO_BANK_FILTER_EN enables the glitch filter
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int                NUM_CH   = 8,
    parameter int                FILT_CNT = GPIO_DEF_FILT_CNT,
    parameter logic [NUM_CH-1:0] PULLUP   = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [NUM_CH-1:0] pad,
    input  logic [NUM_CH-1:0] dout_i,
    input  logic [NUM_CH-1:0] oe_i,
    input  logic [NUM_CH-1:0] od_i,
    output logic [NUM_CH-1:0] din_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o
);

    // spare channels below the package ceiling; negative means NUM_CH is out of range
    localparam int unused_ch_headroom = GPIO_MAX_CH - NUM_CH;

    logic [NUM_CH-1:0] dout_q;
    logic [NUM_CH-1:0] oe_q;
    logic [NUM_CH-1:0] od_q;

    // drive controls are registered so the pads change one edge after sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            oe_q   <= '0;
            od_q   <= '0;
        end else begin
            dout_q <= dout_i;
            oe_q   <= oe_i;
            od_q   <= od_i;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pad_drv_t drv;

        assign drv    = gpio_pad_drive(pad_mode_e'(od_q[g]), oe_q[g], dout_q[g]);
        assign pad[g] = drv.en ? drv.val : 1'bz;

        gpio_filter #(
            .FILT_CNT (FILT_CNT),
            .RST_VAL  (PULLUP[g])
        ) u_filter (
            .clk    (clk),
            .rst    (rst),
            .pad_i  (pad[g]),
            .din_o  (din_o[g]),
            .rise_o (rise_o[g]),
            .fall_o (fall_o[g])
        );
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - self-checking bench for gpio_bank with a behavioural pad/filter model
module tb_gpio_bank;

    localparam int         NCH = 8;
    localparam int         FC  = 4;
    localparam logic [7:0] PU  = 8'h01;
`ifdef GPIO_BANK_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = FC + 2;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dout;
    logic [7:0] oe;
    logic [7:0] od;
    logic [7:0] din;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] tb_val;
    tri1  [7:0] pad_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // channel 0 is left to the DUT and the pull-up; the bench drives the others
    for (genvar g = 1; g < NCH; g++) begin : g_ext
        assign pad_w[g] = tb_val[g];
    end

    gpio_bank #(
        .NUM_CH   (NCH),
        .FILT_CNT (FC),
        .PULLUP   (PU)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pad    (pad_w),
        .dout_i (dout),
        .oe_i   (oe),
        .od_i   (od),
        .din_o  (din),
        .rise_o (rise),
        .fall_o (fall)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: pipeline of pad samples, window of the last FC synchronised levels
    logic [7:0] m_s1;
    logic [7:0] m_s2;
    logic [7:0] m_din;
    logic [7:0] m_rise;
    logic [7:0] m_fall;
    logic       m_pad0;
    logic       m_valid = 1'b0;
    logic [7:0] m_win[$];
    logic [7:0] m_new;
    logic       m_all_diff;

    // model update at each rising edge from the values the DUT samples there
    always @(posedge clk) begin
        if (rst) begin
            m_s1    = PU;
            m_s2    = PU;
            m_din   = PU;
            m_rise  = '0;
            m_fall  = '0;
            m_pad0  = 1'b1;
            m_valid = 1'b1;
            m_win.delete();
        end else begin
            if (oe[0] && !od[0])     m_pad0 = dout[0];
            else if (oe[0] && od[0]) m_pad0 = dout[0];
            else                     m_pad0 = 1'b1;
            if (FILT) begin
                m_win.push_back(m_s2);
                if (m_win.size() > FC) void'(m_win.pop_front());
                m_new = m_din;
                if (m_win.size() == FC) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_all_diff = 1'b1;
                        foreach (m_win[k]) if (m_win[k][c] == m_din[c]) m_all_diff = 1'b0;
                        if (m_all_diff) m_new[c] = ~m_din[c];
                    end
                end
            end else begin
                m_new = m_s1;
            end
            m_rise = m_new & ~m_din;
            m_fall = ~m_new & m_din;
            m_din  = m_new;
            m_s2   = m_s1;
            m_s1   = pad_w;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("din_o", din, m_din);
            check("rise_o", rise, m_rise);
            check("fall_o", fall, m_fall);
            check("pad0", {7'd0, pad_w[0]}, {7'd0, m_pad0});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int first_hi;
    int n_rise;
    int n_fall;
    int hi_cycles;
    int r6;
    int r7;

    initial begin
        rst    = 1'b1;
        dout   = '0;
        oe     = '0;
        od     = '0;
        tb_val = '0;
        repeat (3) @(negedge clk);
        check("reset_din", din, 8'h01);
        check("reset_pulse", rise | fall, 8'h00);

        // release reset with pad[0] pulled high: no pulse, din stays at the pull level
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("release_din", din, 8'h01);
            check("release_rise", rise, 8'h00);
            check("release_fall", fall, 8'h00);
        end

        // push-pull drive on channel 0
        oe[0] = 1'b1; dout[0] = 1'b1;
        @(negedge clk);
        check("pp_drive1", {7'd0, pad_w[0]}, 8'd1);
        dout[0] = 1'b0;
        #1;
        check("pp_hold", {7'd0, pad_w[0]}, 8'd1);
        @(negedge clk);
        check("pp_drive0", {7'd0, pad_w[0]}, 8'd0);
        oe[0] = 1'b0;
        @(negedge clk);
        check("pp_tristate", {7'd0, pad_w[0]}, 8'd1);

        // open-drain drive on channel 0
        od[0] = 1'b1; oe[0] = 1'b1; dout[0] = 1'b1;
        @(negedge clk);
        check("od_release", {7'd0, pad_w[0]}, 8'd1);
        dout[0] = 1'b0;
        @(negedge clk);
        check("od_low", {7'd0, pad_w[0]}, 8'd0);
        dout[0] = 1'b1;
        @(negedge clk);
        check("od_high", {7'd0, pad_w[0]}, 8'd1);
        oe[0] = 1'b0; od[0] = 1'b0; dout[0] = 1'b0;
        repeat (10) @(negedge clk);

        // stable rise on channel 3
        first_hi = 0; n_rise = 0; n_fall = 0;
        tb_val[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first_hi == 0 && din[3]) first_hi = k;
            n_rise += int'(rise[3]);
            n_fall += int'(fall[3]);
        end
        check("lat_ch3", 8'(first_hi), 8'(LAT));
        check("lat_rise_cnt", 8'(n_rise), 8'd1);
        check("lat_fall_cnt", 8'(n_fall), 8'd0);

        // three-cycle glitch on channel 2
        hi_cycles = 0; n_rise = 0; n_fall = 0;
        tb_val[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            hi_cycles += int'(din[2]);
            n_rise += int'(rise[2]);
            n_fall += int'(fall[2]);
            if (k == 3) tb_val[2] = 1'b0;
        end
        check("glitch_din", 8'(hi_cycles), FILT ? 8'd0 : 8'd3);
        check("glitch_rise", 8'(n_rise), FILT ? 8'd0 : 8'd1);
        check("glitch_fall", 8'(n_fall), FILT ? 8'd0 : 8'd1);

        // one-cycle pulse on channel 5
        first_hi = 0; hi_cycles = 0; n_rise = 0; n_fall = 0;
        tb_val[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (first_hi == 0 && din[5]) first_hi = k;
            hi_cycles += int'(din[5]);
            n_rise += int'(rise[5]);
            n_fall += int'(fall[5]);
            if (k == 1) tb_val[5] = 1'b0;
        end
        check("pulse_first", 8'(first_hi), FILT ? 8'd0 : 8'd2);
        check("pulse_width", 8'(hi_cycles), FILT ? 8'd0 : 8'd1);
        check("pulse_rise", 8'(n_rise), FILT ? 8'd0 : 8'd1);
        check("pulse_fall", 8'(n_fall), FILT ? 8'd0 : 8'd1);

        // reset asserted while channel 4 is mid-count
        n_rise = 0; n_fall = 0;
        tb_val[4] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            n_rise += int'(rise[4]);
            n_fall += int'(fall[4]);
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                check("rst_mid_pulse", rise | fall, 8'h00);
                check("rst_mid_din", din, 8'h01);
                rst = 1'b0;
                tb_val[4] = 1'b0;
            end
        end
        check("rst_mid_rise", 8'(n_rise), FILT ? 8'd0 : 8'd1);
        check("rst_mid_fall", 8'(n_fall), 8'd0);

        // simultaneous changes on channels 6 and 7
        r6 = 0; r7 = 0;
        tb_val[7:6] = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (r6 == 0 && rise[6]) r6 = k;
            if (r7 == 0 && rise[7]) r7 = k;
        end
        check("simul_ch6", 8'(r6), 8'(LAT));
        check("simul_ch7", 8'(r7), 8'(LAT));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
